// File: rtl/genesis_pkg.sv
// Shared constants for the Genesis pad responder and reader.
// Button bit indices, phase encoding and default idle timeout.
package genesis_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_START = 5;
  localparam int BTN_Z     = 6;
  localparam int BTN_Y     = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_B     = 9;
  localparam int BTN_C     = 10;

  localparam int TIMEOUT_DEFAULT = 75000;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_1    = 3'd1,
    PH_2    = 3'd2,
    PH_3    = 3'd3,
    PH_4    = 3'd4
  } phase_t;

  function automatic phase_t ph_next(phase_t p);
    phase_t n;
    n = PH_4;
    unique case (p)
      PH_IDLE: n = PH_1;
      PH_1:    n = PH_2;
      PH_2:    n = PH_3;
      default: n = PH_4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sel_sync.sv
// Two-flop synchroniser for the select line.
// Resets to 1 so the line reads as idle-high.
module sel_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
    end
  end

  assign o_sync = r_s2;

endmodule

// File: rtl/genesis_pad_responder.sv
// Emulates a 6-button Genesis pad on the DB-9 pins.
// Select falling edges step the phase; idle timeout rewinds it.
module genesis_pad_responder
  import genesis_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selectSignal,
  input  logic [10:0] buttonsIn,
  output logic        up_z,
  output logic        down_y,
  output logic        left_x,
  output logic        right,
  output logic        a_b,
  output logic        start_c
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TPRE = TW'(TIMEOUT_CYCLES - 1);

  logic          w_sel;
  logic          w_fall;
  logic          w_to;
  logic          w_lo3;
  logic [10:0]   w_b;
  logic [5:0]    w_pins;
  logic          r_sel_d;
  logic          r_hold;
  phase_t        r_ph;
  logic [TW-1:0] r_tmr;
  logic [5:0]    r_pins;

  sel_sync u_sel_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (selectSignal),
    .o_sync  (w_sel)
  );

  assign w_fall = r_sel_d & ~w_sel;
  // True in the cycle tmr reaches the limit, and while it sits there.
  assign w_to   = (r_tmr >= TPRE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_d <= 1'b0;
      r_ph    <= PH_IDLE;
      r_tmr   <= '0;
    end else begin
      r_sel_d <= w_sel;
      if (w_fall) begin
        r_tmr <= '0;
        r_ph  <= w_to ? PH_1 : ph_next(r_ph);
      end else begin
        if (r_tmr != TMAX) r_tmr <= r_tmr + 1'b1;
        if (w_to) r_ph <= PH_IDLE;
      end
    end
  end

  assign w_b   = ~buttonsIn;
  assign w_lo3 = (r_ph <= PH_2);

  always_comb begin
    w_pins = 6'h3F;
    unique case (1'b1)
      (w_sel & w_lo3):
        w_pins = {w_b[BTN_UP], w_b[BTN_DOWN], w_b[BTN_LEFT],
                  w_b[BTN_RIGHT], w_b[BTN_B], w_b[BTN_C]};
      (w_sel & ~w_lo3):
        w_pins = {w_b[BTN_Z], w_b[BTN_Y], w_b[BTN_X],
                  1'b1, w_b[BTN_B], w_b[BTN_C]};
      (~w_sel & w_lo3):
        w_pins = {w_b[BTN_UP], w_b[BTN_DOWN], 2'b00,
                  w_b[BTN_A], w_b[BTN_START]};
      (~w_sel & (r_ph == PH_3)):
        w_pins = {4'b0000, w_b[BTN_A], w_b[BTN_START]};
      default:
        w_pins = {4'b1111, w_b[BTN_A], w_b[BTN_START]};
    endcase
  end

  // r_hold keeps pins released for one extra cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= 1'b1;
      r_pins <= 6'h3F;
    end else begin
      r_hold <= 1'b0;
      r_pins <= r_hold ? 6'h3F : w_pins;
    end
  end

  assign {up_z, down_y, left_x, right, a_b, start_c} = r_pins;

endmodule

// File: tb/tb_genesis_pad_responder.sv
// Directed bench for genesis_pad_responder.
// Pin vector order: pins 1,2,3,4,6,9.
module tb_genesis_pad_responder;

  localparam int T = 100;

  logic        clk;
  logic        reset;
  logic        selectSignal;
  logic [10:0] buttonsIn;
  logic        up_z;
  logic        down_y;
  logic        left_x;
  logic        right;
  logic        a_b;
  logic        start_c;

  int n_chk;
  int n_err;

  genesis_pad_responder #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .selectSignal (selectSignal),
    .buttonsIn    (buttonsIn),
    .up_z         (up_z),
    .down_y       (down_y),
    .left_x       (left_x),
    .right        (right),
    .a_b          (a_b),
    .start_c      (start_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pins();
    return {10'd0, up_z, down_y, left_x, right, a_b, start_c};
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    selectSignal = 1'b1;
    reset = 1'b1;
    cyc(n);
    reset = 1'b0;
  endtask

  task automatic pulse();
    selectSignal = 1'b0;
    cyc(10);
    selectSignal = 1'b1;
    cyc(10);
  endtask

  initial begin
    int k;
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    selectSignal = 1'b1;
    buttonsIn = 11'h7FF;

    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("rst_pins", pins(), 16'h3F);
    end
    reset = 1'b0;
    cyc(1);
    chk("rst_after", pins(), 16'h3F);
    cyc(1);
    chk("all_pressed", pins(), 16'h00);

    // 3-button read
    buttonsIn = 11'h201;
    cyc(5);
    chk("b3_high", pins(), 16'b011101);
    buttonsIn = 11'h402;
    cyc(1);
    chk("btn_lat", pins(), 16'b101110);
    buttonsIn = 11'h201;
    selectSignal = 1'b0;
    cyc(5);
    chk("b3_low", pins(), 16'b010011);
    chk("b3_ph", 16'(dut.r_ph), 16'd1);
    selectSignal = 1'b1;
    cyc(5);

    // 6-button sequence
    do_reset(2);
    buttonsIn = 11'h160;
    selectSignal = 1'b0;
    cyc(10);
    chk("b6_low1", pins(), 16'b110010);
    selectSignal = 1'b1;
    cyc(10);
    chk("b6_high1", pins(), 16'b111111);
    selectSignal = 1'b0;
    cyc(10);
    chk("b6_low2", pins(), 16'b110010);
    selectSignal = 1'b1;
    cyc(10);
    selectSignal = 1'b0;
    cyc(10);
    chk("b6_low3", pins(), 16'b000010);
    selectSignal = 1'b1;
    cyc(10);
    chk("b6_high3", pins(), 16'b010111);
    selectSignal = 1'b0;
    cyc(10);
    chk("b6_low4", pins(), 16'b111110);
    chk("b6_ph4", 16'(dut.r_ph), 16'd4);
    selectSignal = 1'b1;
    cyc(10);
    chk("b6_high4", pins(), 16'b010111);

    // timeout
    do_reset(2);
    buttonsIn = 11'h201;
    pulse();
    pulse();
    chk("to_ph2", 16'(dut.r_ph), 16'd2);
    cyc(T + 1);
    chk("to_ph0", 16'(dut.r_ph), 16'd0);
    chk("to_tmr", 16'(dut.r_tmr), 16'(T));
    selectSignal = 1'b0;
    cyc(5);
    chk("to_low", pins(), 16'b010011);
    chk("to_ph1", 16'(dut.r_ph), 16'd1);
    selectSignal = 1'b1;
    cyc(5);

    // falling edge in the exact timeout cycle
    do_reset(2);
    pulse();
    pulse();
    k = 0;
    while (16'(dut.r_tmr) != 16'(T - 3) && k < 300) begin
      cyc(1);
      k++;
    end
    chk("coin_wait", 16'(k < 300), 16'd1);
    selectSignal = 1'b0;
    cyc(3);
    chk("coin_ph", 16'(dut.r_ph), 16'd1);
    chk("coin_tmr", 16'(dut.r_tmr), 16'd0);
    selectSignal = 1'b1;
    cyc(5);

    // reset mid-sequence
    do_reset(2);
    pulse();
    pulse();
    selectSignal = 1'b0;
    cyc(10);
    chk("mid_low3", pins(), 16'b000011);
    selectSignal = 1'b1;
    cyc(5);
    do_reset(2);
    selectSignal = 1'b0;
    cyc(5);
    chk("mid_low", pins(), 16'b010011);
    chk("mid_ph", 16'(dut.r_ph), 16'd1);
    selectSignal = 1'b1;
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/genesis_pad_responder.md
GENESIS_PAD_RESPONDER -- requirements
Module: genesis_pad_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 75000 (1.5 ms at 50 MHz), select-idle cycles before the phase counter returns to 0.
REQ-002 SHALL have port clk  input  1  single system clock; all state on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port selectSignal  input  1  DB-9 pin 7, driven by the console/reader side; asynchronous to clk.
REQ-005 SHALL have port buttonsIn  input  11  button state, 1 = pressed; bits 0 Up, 1 Down, 2 Left, 3 Right, 4 A, 5 Start, 6 Z, 7 Y, 8 X, 9 B, 10 C.
REQ-006 SHALL have ports up_z, down_y, left_x, right, a_b, start_c  output  1 each  DB-9 pins 1, 2, 3, 4, 6 and 9; active-low, 0 = pressed or forced low.

Function
REQ-007 SHALL synchronise selectSignal through two flip-flops before any use; sel_s denotes the synchronised value.
REQ-008 SHALL detect a falling edge of sel_s (1 to 0) with one extra history register.
REQ-009 SHALL keep phase counter ph (3 bits), incremented on each sel_s falling edge and saturating at 4.
REQ-010 SHALL keep idle timer tmr, cleared on each sel_s falling edge, else incremented, saturating at TIMEOUT_CYCLES.
REQ-011 SHALL set ph to 0 in the cycle tmr reaches TIMEOUT_CYCLES.
REQ-012 SHALL give a falling edge priority when it coincides with timeout: ph = 1 and tmr = 0.
REQ-013 SHALL drive pins from registers, recomputed every cycle from sel_s, ph and the current buttonsIn, using the following table.
REQ-014 SHALL, when sel_s = 1 and ph <= 2, drive Up, Down, Left, Right, B and C on pins 1, 2, 3, 4, 6 and 9.
REQ-015 SHALL, when sel_s = 0 and ph in {0, 1, 2}, drive Up, Down, 0, 0, A and Start.
REQ-016 SHALL, when sel_s = 0 and ph = 3, drive 0, 0, 0, 0, A and Start (the 6-button ID).
REQ-017 SHALL, when sel_s = 1 and ph >= 3, drive Z, Y, X, 1 (no Mode key), B and C.
REQ-018 SHALL, when sel_s = 0 and ph = 4, drive 1, 1, 1, 1, A and Start.
REQ-019 SHALL invert every button before driving its pin (pressed gives 0).
REQ-020 SHALL update pins within 3 clk cycles of a selectSignal change (2 sync stages plus the output register), and within 1 cycle of a buttonsIn change.
REQ-021 SHALL pass simultaneous presses through unchanged, with no debouncing or masking.

Reset
REQ-022 SHALL, while reset = 1 at posedge clk, clear ph, tmr and the edge history, and set both sync stages to 1 (select idle high).
REQ-023 SHALL drive all six pins to 1 (all released) during reset and in the first cycle after reset.
REQ-024 SHALL abandon any sequence in progress on reset, so the next falling edge yields ph = 1.

Structure
REQ-025 SHALL take bit-index constants (BTN_UP … BTN_C), phase constants (PH_IDLE … PH_4) and the default TIMEOUT_CYCLES from shared package genesis_pkg, which is also used by the reader block.
REQ-026 SHALL instantiate one sub-module, sel_sync, a two-flop synchroniser with a synchronous reset value of 1.
REQ-027 SHALL keep the pin-mapping table as one combinational block feeding the output register, with no additional latency stages.

Verification (TIMEOUT_CYCLES = 100 in bench)
REQ-028 SHALL cover reset release: reset = 1 for 3 cycles with buttonsIn = 11'h7FF -> all pins = 1 during reset and in the cycle after.
REQ-029 SHALL cover a 3-button read: buttonsIn = Up|B (bits 0, 9), select high -> pins 1..9 = 0,1,1,1,0,1; select low -> 0,1,0,0,1,1.
REQ-030 SHALL cover a 6-button sequence with buttonsIn = Z|X|Start and 4 select pulses 20 cycles apart -> third low gives 0,0,0,0,1,0; fourth high gives 0,1,0,1,1,1; fourth low gives 1,1,1,1,1,0.
REQ-031 SHALL cover timeout: 2 falling edges, then select high for 101 cycles, then a falling edge -> ph = 1 and the 3-button low pattern, not the ID pattern.
REQ-032 SHALL cover the coincidence case: a falling edge arriving in the exact timeout cycle -> ph = 1 and tmr = 0 on the next cycle.
REQ-033 SHALL cover reset mid-sequence: reset after the 3rd falling edge, then 1 pulse -> select low shows the 3-button pattern (ph = 1).
